// File: rtl/sc_muldiv_if.sv
//------------------------------------------------------------------------------
// Module  : sc_muldiv_if
// Brief   : Request/result bundle between the control unit and sc_muldiv.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sc_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       mdop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, mdop, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mdop, a, b,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/sc_muldiv.sv
//------------------------------------------------------------------------------
// Module  : sc_muldiv
// Brief   : Iterative shift-add multiplier / restoring divider with HI/LO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sc_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic  clock,
    input  wire logic  resetn,
    sc_muldiv_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_madd  = 4'd5;
    localparam logic [3:0] c_op_maddu = 4'd6;
    localparam logic [3:0] c_op_msub  = 4'd7;
    localparam logic [3:0] c_op_msubu = 4'd8;
    localparam logic [3:0] c_op_mthi  = 4'd9;
    localparam logic [3:0] c_op_mtlo  = 4'd10;

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_divz;

    // ---- request decode ----
    logic             w_signed;
    logic             w_is_div;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    always_comb begin
        w_signed   = (bus.mdop == c_op_mult) || (bus.mdop == c_op_div) ||
                     (bus.mdop == c_op_madd) || (bus.mdop == c_op_msub);
        w_is_div   = (bus.mdop == c_op_div) || (bus.mdop == c_op_divu);
        w_is_arith = (bus.mdop >= c_op_mult) && (bus.mdop <= c_op_msubu);
        w_a_mag    = (w_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
        w_b_mag    = (w_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    end

    // ---- one iteration datapath ----
    logic            r_op_div;
    logic [WIDTH:0]  w_sum;
    logic [WIDTH:0]  w_shift;
    logic [WIDTH:0]  w_diff;
    logic            w_ge;

    assign r_op_div = (r_op == c_op_div) || (r_op == c_op_divu);

    always_comb begin
        w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                  (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_shift = {r_rem, r_prod[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_opnd};
        // Partial remainder is always below twice the divisor, so bit WIDTH
        // of the difference is set exactly when the subtraction borrows.
        w_ge    = ~w_diff[WIDTH];
    end

    // ---- sign fix-up and commit value ----
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_hilo_next;

    always_comb begin
        w_prod_fix = r_neg_res ? (~r_prod + 1'b1) : r_prod;
        w_quo_fix  = r_neg_res ? (~r_prod[WIDTH-1:0] + 1'b1) : r_prod[WIDTH-1:0];
        w_rem_fix  = r_neg_rem ? (~r_rem + 1'b1) : r_rem;
        w_hilo     = {r_hi, r_lo};
        case (r_op)
            c_op_madd, c_op_maddu: w_hilo_next = w_hilo + w_prod_fix;
            c_op_msub, c_op_msubu: w_hilo_next = w_hilo - w_prod_fix;
            default:               w_hilo_next = w_prod_fix;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= c_st_idle;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a_raw   <= '0;
            r_opnd    <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.start && (bus.mdop == c_op_mthi)) begin
                        r_hi <= bus.a;
                    end else if (bus.start && (bus.mdop == c_op_mtlo)) begin
                        r_lo <= bus.a;
                    end else if (bus.start && w_is_arith) begin
                        r_state   <= c_st_run;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_op      <= bus.mdop;
                        r_a_raw   <= bus.a;
                        r_rem     <= '0;
                        r_neg_res <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_rem <= w_signed && bus.a[WIDTH-1];
                        r_divz    <= w_is_div && (bus.b == '0);
                        // Multiply: multiplicand in r_opnd, multiplier in low half.
                        // Divide: divisor in r_opnd, dividend shifts out of low half.
                        r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                        r_prod    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                    end
                end
                c_st_run: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_op_div) begin
                        r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_prod <= {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-2:0], w_ge};
                    end else begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_fix;
                    end
                end
                c_st_fix: begin
                    if (r_op_div) begin
                        if (r_divz) begin
                            r_lo <= '1;
                            r_hi <= r_a_raw;
                        end else begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end
                    end else begin
                        {r_hi, r_lo} <= w_hilo_next;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_sc_muldiv.sv
//------------------------------------------------------------------------------
// Module  : tb_sc_muldiv
// Brief   : Directed self-checking bench for sc_muldiv (WIDTH=32).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sc_muldiv;

    localparam logic [3:0] c_mult  = 4'd1;
    localparam logic [3:0] c_multu = 4'd2;
    localparam logic [3:0] c_div   = 4'd3;
    localparam logic [3:0] c_divu  = 4'd4;
    localparam logic [3:0] c_madd  = 4'd5;
    localparam logic [3:0] c_msub  = 4'd7;
    localparam logic [3:0] c_msubu = 4'd8;
    localparam logic [3:0] c_mthi  = 4'd9;
    localparam logic [3:0] c_mtlo  = 4'd10;

    logic clock;
    logic resetn;
    int   n_total;
    int   n_bad;

    sc_muldiv_if #(.WIDTH(32)) bus ();

    sc_muldiv #(.WIDTH(32)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or timeout).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, output int cycles, output int busy_cnt);
        bus.start = 1'b1;
        bus.mdop  = op;
        bus.a     = a;
        bus.b     = b;
        cycles    = 0;
        busy_cnt  = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (bus.busy) busy_cnt++;
            if (cycles == inject_at) begin
                bus.start = 1'b1;
                bus.mdop  = c_mtlo;
                bus.a     = 32'h55;
            end else begin
                bus.start = 1'b0;
            end
        end while (!bus.done && cycles < 60);
        bus.start = 1'b0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.mdop  = op;
        bus.a     = a;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    int cyc;
    int bcnt;
    int seen_done;

    initial begin
        n_total   = 0;
        n_bad     = 0;
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.mdop  = 4'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clock);
        check("rst_hi",   64'(bus.hi), 64'h0);
        check("rst_lo",   64'(bus.lo), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        resetn = 1'b1;
        @(negedge clock);

        run_op(c_mult, 32'hFFFF_FFFD, 32'd5, 0, cyc, bcnt);
        check("mult_latency", 64'(cyc), 64'd34);
        check("mult_busy_cycles", 64'(bcnt), 64'd33);
        check("mult_busy_at_done", 64'(bus.busy), 64'h0);
        check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // back-to-back: issued in the done cycle
        run_op(c_divu, 32'd100, 32'd7, 0, cyc, bcnt);
        check("divu_latency", 64'(cyc), 64'd34);
        check("divu_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

        run_op(c_div, 32'hFFFF_FFF9, 32'd2, 0, cyc, bcnt);
        check("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(c_divu, 32'h1234, 32'd0, 0, cyc, bcnt);
        check("divu_z_latency", 64'(cyc), 64'd34);
        check("divu_z_hilo", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);

        run_op(c_div, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bcnt);
        check("div_ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        run_op(c_div, 32'hFFFF_FFF0, 32'd0, 0, cyc, bcnt);
        check("div_z_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFF0_FFFF_FFFF);

        @(negedge clock);
        move_to(c_mthi, 32'd0);
        check("mthi_hi", 64'(bus.hi), 64'h0);
        check("mthi_nodone", 64'(bus.done), 64'h0);
        move_to(c_mtlo, 32'd10);
        check("mtlo_lo", 64'(bus.lo), 64'd10);
        check("mtlo_nobusy", 64'(bus.busy), 64'h0);

        run_op(c_madd, 32'd3, 32'd4, 0, cyc, bcnt);
        check("madd_hilo", {bus.hi, bus.lo}, {32'd0, 32'd22});

        run_op(c_msubu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, bcnt);
        check("msubu_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_0015);

        // signed MSUB with negative product: subtracting -6 adds 6
        run_op(c_msub, 32'hFFFF_FFFE, 32'd3, 0, cyc, bcnt);
        check("msub_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_001B);

        run_op(c_multu, 32'h1234_5678, 32'h10, 10, cyc, bcnt);
        check("multu_inject_latency", 64'(cyc), 64'd34);
        check("multu_inject_hilo", {bus.hi, bus.lo}, 64'h0000_0001_2345_6780);

        // abort a divide with reset
        @(negedge clock);
        move_to(c_mthi, 32'hAAAA);
        bus.start = 1'b1;
        bus.mdop  = c_div;
        bus.a     = 32'hFFFF_FFEC;
        bus.b     = 32'd6;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (14) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("abort_hi",   64'(bus.hi), 64'h0);
        check("abort_lo",   64'(bus.lo), 64'h0);
        check("abort_busy", 64'(bus.busy), 64'h0);
        seen_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        run_op(c_div, 32'hFFFF_FFEC, 32'd6, 0, cyc, bcnt);
        check("after_abort_latency", 64'(cyc), 64'd34);
        check("after_abort_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_FFFF_FFFD);

        // undefined opcode while idle is a no-op
        @(negedge clock);
        bus.start = 1'b1;
        bus.mdop  = 4'hF;
        bus.a     = 32'h1111;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        check("noop_busy", 64'(bus.busy), 64'h0);
        check("noop_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_FFFF_FFFD);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
